noc_to_rxr_basic: RTL and testbench
===================================

Name: noc_to_rxr_basic

Overview:
Receive-side counterpart of the Avalon-ST-to-NoC transmitter. It accepts flits arriving from a NoC router port. Packets on different virtual channels may interleave flit-by-flit. Each VC's packets are reassembled in a per-VC store-and-forward FIFO, and whole packets are emitted atomically on one Avalon-ST output toward the receive (rxr) pipeline. It also filters control packets, marked by data MSB=1 on the SOP flit, and counts protocol errors.

Parameters:
DATA_WIDTH, 512, flit/beat width in bits; multiple of 64.
NUM_VC, 2, NoC virtual channels.
FIFO_DEPTH, 16, flits per VC FIFO; power of 2; must be >= MAX_PKT_FLITS.
MAX_PKT_FLITS, 16, largest legal packet length in flits.

Ports:
clk  in  1  single clock.
reset  in  1  asynchronous, active-low reset (0 = in reset).
in_valid  in  1  flit present from NoC.
in_sop  in  1  first flit of packet.
in_eop  in  1  last flit of packet.
in_empty  in  log2(DATA_WIDTH/8)  unused bytes in EOP flit.
in_data  in  DATA_WIDTH  flit payload.
i_vc_id  in  log2(NUM_VC)  VC of current flit.
o_vc_ready  out  NUM_VC  per-VC backpressure; bit v=1 means VC v FIFO has >=1 free slot.
out_valid  out  1  Avalon-ST beat valid.
out_sop  out  1  start of packet.
out_eop  out  1  end of packet.
out_empty  out  log2(DATA_WIDTH/8)  empty bytes on EOP beat.
out_data  out  DATA_WIDTH  beat payload.
out_ready  in  1  downstream ready; beat transfers when out_valid & out_ready.
o_vc_id  out  log2(NUM_VC)  VC of packet currently on out.
o_ctrl_drop_cnt  out  32  control packets discarded.
o_err_cnt  out  32  protocol-error flits discarded.

Behaviour:
- Reset (reset=0, async): all FIFOs empty; write-side packet state idle; FSM IDLE; RR pointer 0.
- Outputs in reset: out_valid=0, out_sop=0, out_eop=0, out_empty=0, out_data=0, o_vc_id=0, o_vc_ready=0, counters=0.
- First edge after release: o_vc_ready=all 1s.
- Reset mid-packet discards all partial and complete buffered packets; nothing is replayed.
- Write side, per VC v, state in_pkt[v] plus drop[v]:
  - in_valid & o_vc_ready[v]=0: flit discarded, o_err_cnt++.
  - SOP with in_data[MSB]=1: drop[v]=1. Flits up to and including EOP are not written. o_ctrl_drop_cnt++ at SOP.
  - SOP while in_pkt[v]=1: truncated packet. The partial packet is rolled back (FIFO write pointer restored to the packet start), o_err_cnt++, and the new SOP starts a fresh packet.
  - Non-SOP flit while in_pkt[v]=0 and drop[v]=0: discarded, o_err_cnt++.
  - SOP&EOP in one flit: single-flit packet.
- A packet becomes eligible when its EOP is written. pkt_cnt[v]++ is visible the cycle after the EOP write edge.
- Read FSM:
  - IDLE: round-robin over VCs with pkt_cnt>0, starting at rr_ptr+1. On grant, register o_vc_id and go to STREAM. rr_ptr=granted VC.
  - STREAM: out_* driven from the head of FIFO[o_vc_id] (show-ahead). Pops on out_valid&out_ready. EOP pop: pkt_cnt--, return to IDLE.
  - Output stays on one VC until EOP; no interleaving on out.
- Latency: EOP written at edge t; grant at edge t+1; out_valid=1 with out_sop=1 after edge t+1.
- Back-to-back packets cost one IDLE bubble cycle between EOP and the next SOP.
- out_valid/out_data are held stable while out_ready=0.
- Simultaneous events:
  - Push and pop on the same VC FIFO in one cycle are both honoured.
  - pkt_cnt inc and dec in one cycle leaves it unchanged.
- Counters saturate at 2^32-1.
- o_vc_ready[v] is combinational from free-count>0, independent of out_ready.

Decomposition:
- Shared package noc_rxr_pkg:
  - flit struct {sop, eop, empty, data}.
  - EMPTY_W = $clog2(DATA_WIDTH/8).
  - FSM enum {IDLE, STREAM}.
- One sub-module, rxr_vc_fifo: show-ahead FIFO storing one flit struct per entry. Provides a "mark" pointer saved at SOP and a rollback input that restores the write pointer to it. Instantiated NUM_VC times via generate.

Test Plan:
- 3-flit packet on VC0 with out_ready=1 -> sop beat appears 2 cycles after the EOP flit; 3 beats; o_vc_id=0; out_empty copied on EOP (e.g. 20).
- Two 4-flit packets, VC0 and VC1, flits alternating every cycle -> out carries all of VC0 then all of VC1 (RR from ptr 0 picks VC1 if both complete simultaneously); no beat interleaving.
- SOP flit with data[511]=1 (2-flit control packet) on VC1 followed by a normal packet -> only the normal packet is output; o_ctrl_drop_cnt=1.
- VC0 SOP, 1 flit, then new SOP, then EOP -> only the 2-flit second packet is output; o_err_cnt=1.
- out_ready=0 while 16 flits are pushed on VC0 -> o_vc_ready[0]=0 after the 16th push. A 17th flit is dropped and o_err_cnt=1; o_vc_ready[1] stays 1.
- reset pulsed low mid-STREAM -> out_valid=0 immediately (async); after release, counters=0 and no stale beats are emitted.

Source files
------------

// File: rtl/noc_rxr_pkg.sv
// noc_rxr_pkg: flit layout, sizing constants and FSM states shared by the NoC receiver.
package noc_rxr_pkg;
   localparam int DATA_WIDTH    = 512;
   localparam int MAX_PKT_FLITS = 16;
   localparam int EMPTY_W       = $clog2(DATA_WIDTH / 8);
   typedef struct packed {
      logic               sop;
      logic               eop;
      logic [EMPTY_W-1:0] empty;
      logic [DATA_WIDTH-1:0] data;
   } flit_t;
   typedef enum logic {IDLE, STREAM} state_t;
   function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic ev);
      return (ev && c != '1) ? c + 32'd1 : c;
   endfunction
endpackage

// File: rtl/noc_to_rxr_basic_if.sv
// noc_to_rxr_basic_if: NoC flit input, Avalon-ST packet output and status counters of the receiver.
interface noc_to_rxr_basic_if import noc_rxr_pkg::*; #(parameter int NUM_VC = 2);
   localparam int VC_W = $clog2(NUM_VC);
   logic                  in_valid;
   logic                  in_sop;
   logic                  in_eop;
   logic [EMPTY_W-1:0]    in_empty;
   logic [DATA_WIDTH-1:0] in_data;
   logic [VC_W-1:0]       i_vc_id;
   logic [NUM_VC-1:0]     o_vc_ready;
   logic                  out_valid;
   logic                  out_sop;
   logic                  out_eop;
   logic [EMPTY_W-1:0]    out_empty;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_ready;
   logic [VC_W-1:0]       o_vc_id;
   logic [31:0]           o_ctrl_drop_cnt;
   logic [31:0]           o_err_cnt;
   modport slave (
      input  in_valid, in_sop, in_eop, in_empty, in_data, i_vc_id, out_ready,
      output o_vc_ready, out_valid, out_sop, out_eop, out_empty, out_data, o_vc_id,
             o_ctrl_drop_cnt, o_err_cnt
   );
   modport master (
      output in_valid, in_sop, in_eop, in_empty, in_data, i_vc_id, out_ready,
      input  o_vc_ready, out_valid, out_sop, out_eop, out_empty, out_data, o_vc_id,
             o_ctrl_drop_cnt, o_err_cnt
   );
endinterface

// File: rtl/rxr_vc_fifo.sv
// rxr_vc_fifo: show-ahead flit FIFO whose write pointer can roll back to the start of
// the packet being written, so a truncated packet leaves no trace.
module rxr_vc_fifo import noc_rxr_pkg::*; #(parameter int DEPTH = 16) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  push_i,
   input  logic  mark_i,
   input  logic  rollback_i,
   input  flit_t wdata_i,
   input  logic  pop_i,
   output flit_t rdata_o,
   output logic  ready_o
);
   localparam int AW = $clog2(DEPTH);
   flit_t mem_q [DEPTH];
   logic [AW:0] wptr_q, wptr_d, rptr_q, mark_q, base;
   // A rollback and a fresh SOP in the same cycle overwrite the abandoned packet in place.
   assign base    = rollback_i ? mark_q : wptr_q;
   assign wptr_d  = push_i ? base + 1'b1 : base;
   assign rdata_o = mem_q[rptr_q[AW-1:0]];
   assign ready_o = (wptr_q - rptr_q) != (AW+1)'(DEPTH);
   always_ff @(posedge clk)
      if (push_i) mem_q[base[AW-1:0]] <= wdata_i;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         mark_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         if (pop_i) rptr_q <= rptr_q + 1'b1;
         if (push_i && mark_i) mark_q <= base;
      end
endmodule

// File: rtl/noc_to_rxr_basic.sv
// noc_to_rxr_basic: reassembles VC-interleaved NoC flits into per-VC packets and emits
// whole packets on one Avalon-ST output, dropping control packets and counting errors.
module noc_to_rxr_basic import noc_rxr_pkg::*; #(
   parameter int NUM_VC     = 2,
   parameter int FIFO_DEPTH = MAX_PKT_FLITS
) (
   input logic               clk,
   input logic               reset,
   noc_to_rxr_basic_if.slave bus
);
   localparam int VC_W = $clog2(NUM_VC);
   localparam int CW   = $clog2(FIFO_DEPTH + 1);
   logic [VC_W-1:0]   v, grant, idx, vc_q, rr_q;
   logic [NUM_VC-1:0] in_pkt_q, in_pkt_d, drop_q, drop_d, push, rollback, pop, inc, dec;
   logic [NUM_VC-1:0] fifo_rdy, vc_ready;
   logic [CW-1:0]     pkt_cnt_q [NUM_VC];
   logic [31:0]       ctrl_cnt_q, err_cnt_q;
   logic              ready_en_q, err, ctrl, grant_ok, out_valid, fire;
   flit_t             wflit, cur;
   flit_t             head [NUM_VC];
   state_t            state_q;

   assign v        = bus.i_vc_id;
   assign vc_ready = fifo_rdy & {NUM_VC{ready_en_q}};
   assign wflit    = '{sop: bus.in_sop, eop: bus.in_eop, empty: bus.in_empty, data: bus.in_data};

   always_comb begin
      in_pkt_d = in_pkt_q;
      drop_d   = drop_q;
      push     = '0;
      rollback = '0;
      inc      = '0;
      err      = 1'b0;
      ctrl     = bus.in_valid && vc_ready[v] && bus.in_sop && bus.in_data[DATA_WIDTH-1];
      if (bus.in_valid && !vc_ready[v]) err = 1'b1;
      else if (bus.in_valid && bus.in_sop) begin
         err         = in_pkt_q[v];
         rollback[v] = in_pkt_q[v];
         push[v]     = !ctrl;
         inc[v]      = !ctrl && bus.in_eop;
         in_pkt_d[v] = !ctrl && !bus.in_eop;
         drop_d[v]   = ctrl && !bus.in_eop;
      end else if (bus.in_valid && drop_q[v]) drop_d[v] = !bus.in_eop;
      else if (bus.in_valid && in_pkt_q[v]) begin
         push[v]     = 1'b1;
         inc[v]      = bus.in_eop;
         in_pkt_d[v] = !bus.in_eop;
      end else err = bus.in_valid;
   end

   for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
      rxr_vc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk       (clk),
         .rst_n     (reset),
         .push_i    (push[i]),
         .mark_i    (wflit.sop),
         .rollback_i(rollback[i]),
         .wdata_i   (wflit),
         .pop_i     (pop[i]),
         .rdata_o   (head[i]),
         .ready_o   (fifo_rdy[i])
      );
   end

   // Scan downward so the VC nearest after rr_q is the one left in grant.
   always_comb begin
      grant_ok = 1'b0;
      grant    = rr_q;
      idx      = rr_q;
      for (int k = NUM_VC; k >= 1; k--) begin
         idx = VC_W'((int'(rr_q) + k) % NUM_VC);
         if (pkt_cnt_q[idx] != '0) begin
            grant_ok = 1'b1;
            grant    = idx;
         end
      end
   end

   assign cur       = head[vc_q];
   assign out_valid = state_q == STREAM;
   assign fire      = out_valid && bus.out_ready;
   always_comb begin
      pop       = '0;
      pop[vc_q] = fire;
   end
   assign dec = pop & {NUM_VC{cur.eop}};

   assign bus.o_vc_ready      = vc_ready;
   assign bus.out_valid       = out_valid;
   assign bus.out_sop         = out_valid && cur.sop;
   assign bus.out_eop         = out_valid && cur.eop;
   assign bus.out_empty       = out_valid ? cur.empty : '0;
   assign bus.out_data        = out_valid ? cur.data : '0;
   assign bus.o_vc_id         = vc_q;
   assign bus.o_ctrl_drop_cnt = ctrl_cnt_q;
   assign bus.o_err_cnt       = err_cnt_q;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         vc_q    <= '0;
         rr_q    <= '0;
      end else if (state_q == IDLE) begin
         if (grant_ok) begin
            state_q <= STREAM;
            vc_q    <= grant;
            rr_q    <= grant;
         end
      end else if (fire && cur.eop) state_q <= IDLE;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         ready_en_q <= 1'b0;
         in_pkt_q   <= '0;
         drop_q     <= '0;
         ctrl_cnt_q <= '0;
         err_cnt_q  <= '0;
         for (int i = 0; i < NUM_VC; i++) pkt_cnt_q[i] <= '0;
      end else begin
         ready_en_q <= 1'b1;
         in_pkt_q   <= in_pkt_d;
         drop_q     <= drop_d;
         ctrl_cnt_q <= sat_inc(ctrl_cnt_q, ctrl);
         err_cnt_q  <= sat_inc(err_cnt_q, err);
         for (int i = 0; i < NUM_VC; i++) pkt_cnt_q[i] <= pkt_cnt_q[i] + CW'(inc[i]) - CW'(dec[i]);
      end
endmodule

// File: tb/tb_noc_to_rxr_basic.sv
// tb_noc_to_rxr_basic: directed vectors with hand-computed expectations for the NoC receiver.
module tb_noc_to_rxr_basic;
   import noc_rxr_pkg::*;
   typedef struct {
      logic sop;
      logic eop;
      logic [EMPTY_W-1:0] empty;
      logic [DATA_WIDTH-1:0] data;
      logic vc;
      int cyc;
   } beat_t;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int cyc = 0, tests = 0, fails = 0, err_exp = 0, ctrl_exp = 0;
   beat_t beats[$];

   noc_to_rxr_basic_if #(.NUM_VC(2)) bus ();
   noc_to_rxr_basic #(.NUM_VC(2), .FIFO_DEPTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
         beats.push_back('{bus.out_sop, bus.out_eop, bus.out_empty, bus.out_data, bus.o_vc_id, cyc});

   task automatic send(input int vc, input bit s, input bit e, input int emp, input logic [DATA_WIDTH-1:0] d);
      bus.in_valid = 1'b1;
      bus.in_sop   = s;
      bus.in_eop   = e;
      bus.in_empty = EMPTY_W'(emp);
      bus.in_data  = d;
      bus.i_vc_id  = 1'(vc);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'b0;
      bus.in_eop   = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < 300 && beats.size() < n; i++) @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #3;
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %0b expected 0", bus.out_valid); end
      tests++; if (bus.out_data !== '0) begin fails++; $display("FAIL rst_out_data: got %0h expected 0", bus.out_data); end
      tests++; if (bus.o_vc_ready !== 2'b00) begin fails++; $display("FAIL rst_vc_ready: got %0b expected 00", bus.o_vc_ready); end
      tests++; if (bus.o_err_cnt !== 32'd0 || bus.o_ctrl_drop_cnt !== 32'd0) begin fails++; $display("FAIL rst_counters: got %0d/%0d expected 0/0", bus.o_err_cnt, bus.o_ctrl_drop_cnt); end
      tests++; if (bus.o_vc_id !== 1'b0) begin fails++; $display("FAIL rst_vc_id: got %0b expected 0", bus.o_vc_id); end
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      tests++; if (bus.o_vc_ready !== 2'b00) begin fails++; $display("FAIL ready_before_edge: got %0b expected 00", bus.o_vc_ready); end
      @(posedge clk);
      #1;
      tests++; if (bus.o_vc_ready !== 2'b11) begin fails++; $display("FAIL ready_after_edge: got %0b expected 11", bus.o_vc_ready); end
   endtask

   task automatic test_basic;
      int t;
      beats.delete();
      send(0, 1, 0, 0, 512'h101);
      send(0, 0, 0, 0, 512'h102);
      send(0, 0, 1, 20, 512'h103);
      t = cyc;
      drain(3);
      tests++; if (beats.size() !== 3) begin fails++; $display("FAIL basic_count: got %0d expected 3", beats.size()); end
      if (beats.size() > 0) begin
         tests++; if (beats[0].cyc !== t + 1) begin fails++; $display("FAIL basic_latency: got cycle %0d expected %0d", beats[0].cyc, t + 1); end
      end
      for (int i = 0; i < beats.size() && i < 3; i++) begin
         tests++;
         if (beats[i].data !== 512'h101 + i || beats[i].sop !== (i == 0) || beats[i].eop !== (i == 2) ||
             beats[i].empty !== EMPTY_W'(i == 2 ? 20 : 0) || beats[i].vc !== 1'b0) begin
            fails++;
            $display("FAIL basic_beat%0d: got data %0h sop %0b eop %0b empty %0d vc %0b expected data %0h sop %0b eop %0b empty %0d vc 0",
                     i, beats[i].data, beats[i].sop, beats[i].eop, beats[i].empty, beats[i].vc,
                     512'h101 + i, i == 0, i == 2, i == 2 ? 20 : 0);
         end
      end
   endtask

   task automatic test_interleave;
      beats.delete();
      for (int i = 0; i < 4; i++) begin
         send(0, i == 0, i == 3, 0, 512'h601 + i);
         send(1, i == 0, i == 3, 0, 512'h701 + i);
      end
      drain(8);
      tests++; if (beats.size() !== 8) begin fails++; $display("FAIL ilv_count: got %0d expected 8", beats.size()); end
      for (int i = 0; i < beats.size() && i < 8; i++) begin
         tests++;
         if (beats[i].vc !== (i >= 4) || beats[i].data !== (i < 4 ? 512'h601 + i : 512'h701 + i - 4) ||
             beats[i].sop !== (i % 4 == 0) || beats[i].eop !== (i % 4 == 3)) begin
            fails++;
            $display("FAIL ilv_beat%0d: got vc %0b data %0h sop %0b eop %0b expected vc %0b data %0h",
                     i, beats[i].vc, beats[i].data, beats[i].sop, beats[i].eop, i >= 4, i < 4 ? 512'h601 + i : 512'h701 + i - 4);
         end
      end
      if (beats.size() >= 8) begin
         tests++; if (beats[4].cyc - beats[3].cyc !== 2) begin fails++; $display("FAIL ilv_bubble: got gap %0d expected 2", beats[4].cyc - beats[3].cyc); end
      end
   endtask

   task automatic test_ctrl;
      logic [DATA_WIDTH-1:0] d;
      beats.delete();
      d = 512'h201;
      d[DATA_WIDTH-1] = 1'b1;
      send(1, 1, 0, 0, d);
      send(1, 0, 1, 0, 512'h202);
      send(1, 1, 0, 0, 512'h211);
      send(1, 0, 1, 7, 512'h212);
      ctrl_exp++;
      drain(2);
      tests++; if (beats.size() !== 2) begin fails++; $display("FAIL ctrl_count: got %0d expected 2", beats.size()); end
      for (int i = 0; i < beats.size() && i < 2; i++) begin
         tests++;
         if (beats[i].data !== 512'h211 + i || beats[i].vc !== 1'b1 || beats[i].empty !== EMPTY_W'(i == 1 ? 7 : 0)) begin
            fails++;
            $display("FAIL ctrl_beat%0d: got data %0h vc %0b empty %0d expected data %0h vc 1 empty %0d",
                     i, beats[i].data, beats[i].vc, beats[i].empty, 512'h211 + i, i == 1 ? 7 : 0);
         end
      end
      tests++; if (bus.o_ctrl_drop_cnt !== 32'(ctrl_exp)) begin fails++; $display("FAIL ctrl_drop_cnt: got %0d expected %0d", bus.o_ctrl_drop_cnt, ctrl_exp); end
      tests++; if (bus.o_err_cnt !== 32'(err_exp)) begin fails++; $display("FAIL ctrl_err_cnt: got %0d expected %0d", bus.o_err_cnt, err_exp); end
   endtask

   task automatic test_truncate;
      beats.delete();
      send(0, 1, 0, 0, 512'h401);
      send(0, 1, 0, 0, 512'h411);
      send(0, 0, 1, 3, 512'h412);
      err_exp++;
      drain(2);
      tests++; if (beats.size() !== 2) begin fails++; $display("FAIL trunc_count: got %0d expected 2", beats.size()); end
      for (int i = 0; i < beats.size() && i < 2; i++) begin
         tests++;
         if (beats[i].data !== 512'h411 + i || beats[i].sop !== (i == 0) || beats[i].eop !== (i == 1)) begin
            fails++;
            $display("FAIL trunc_beat%0d: got data %0h sop %0b eop %0b expected data %0h", i, beats[i].data, beats[i].sop, beats[i].eop, 512'h411 + i);
         end
      end
      tests++; if (bus.o_err_cnt !== 32'(err_exp)) begin fails++; $display("FAIL trunc_err_cnt: got %0d expected %0d", bus.o_err_cnt, err_exp); end
   endtask

   task automatic test_full;
      beats.delete();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         send(0, i == 0, i == 15, 0, 512'h300 + i);
         if (i == 14) begin
            tests++; if (bus.o_vc_ready !== 2'b11) begin fails++; $display("FAIL full_ready_15: got %0b expected 11", bus.o_vc_ready); end
         end
      end
      tests++; if (bus.o_vc_ready !== 2'b10) begin fails++; $display("FAIL full_ready_16: got %0b expected 10", bus.o_vc_ready); end
      send(0, 1, 1, 0, 512'h3FF);
      err_exp++;
      tests++; if (bus.o_err_cnt !== 32'(err_exp)) begin fails++; $display("FAIL full_err_cnt: got %0d expected %0d", bus.o_err_cnt, err_exp); end
      tests++; if (bus.o_vc_ready[1] !== 1'b1) begin fails++; $display("FAIL full_ready_vc1: got %0b expected 1", bus.o_vc_ready[1]); end
      repeat (3) @(negedge clk);
      tests++; if (bus.out_valid !== 1'b1 || bus.out_sop !== 1'b1 || bus.out_data !== 512'h300) begin fails++; $display("FAIL stall_head: got valid %0b sop %0b data %0h expected 1 1 300", bus.out_valid, bus.out_sop, bus.out_data); end
      repeat (2) @(negedge clk);
      tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 512'h300) begin fails++; $display("FAIL stall_hold: got valid %0b data %0h expected 1 300", bus.out_valid, bus.out_data); end
      tests++; if (beats.size() !== 0) begin fails++; $display("FAIL stall_no_beats: got %0d expected 0", beats.size()); end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      drain(16);
      tests++; if (beats.size() !== 16) begin fails++; $display("FAIL full_count: got %0d expected 16", beats.size()); end
      for (int i = 0; i < beats.size() && i < 16; i++) begin
         tests++;
         if (beats[i].data !== 512'h300 + i || beats[i].eop !== (i == 15) || beats[i].vc !== 1'b0) begin
            fails++;
            $display("FAIL full_beat%0d: got data %0h eop %0b vc %0b expected data %0h eop %0b vc 0", i, beats[i].data, beats[i].eop, beats[i].vc, 512'h300 + i, i == 15);
         end
      end
   endtask

   task automatic test_reset_mid;
      beats.delete();
      for (int i = 0; i < 4; i++) send(1, i == 0, i == 3, 0, 512'h501 + i);
      for (int i = 0; i < 30 && bus.out_valid !== 1'b1; i++) @(negedge clk);
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL mid_stream_start: got %0b expected 1", bus.out_valid); end
      #2 reset = 1'b0;
      #1;
      err_exp = 0;
      ctrl_exp = 0;
      tests++; if (bus.out_valid !== 1'b0 || bus.out_sop !== 1'b0 || bus.out_data !== '0) begin fails++; $display("FAIL mid_async: got valid %0b sop %0b data %0h expected 0 0 0", bus.out_valid, bus.out_sop, bus.out_data); end
      tests++; if (bus.o_err_cnt !== 32'(err_exp) || bus.o_ctrl_drop_cnt !== 32'(ctrl_exp)) begin fails++; $display("FAIL mid_counters: got %0d/%0d expected 0/0", bus.o_err_cnt, bus.o_ctrl_drop_cnt); end
      @(posedge clk);
      #2 reset = 1'b1;
      beats.delete();
      repeat (12) @(posedge clk);
      #1;
      tests++; if (beats.size() !== 0) begin fails++; $display("FAIL mid_stale: got %0d beats expected 0", beats.size()); end
      tests++; if (bus.o_vc_ready !== 2'b11) begin fails++; $display("FAIL mid_ready: got %0b expected 11", bus.o_vc_ready); end
      send(1, 1, 1, 9, 512'h5AA);
      drain(1);
      tests++; if (beats.size() !== 1) begin fails++; $display("FAIL mid_after_count: got %0d expected 1", beats.size()); end
      if (beats.size() > 0) begin
         tests++;
         if (beats[0].data !== 512'h5AA || beats[0].empty !== EMPTY_W'(9) || beats[0].sop !== 1'b1 || beats[0].eop !== 1'b1 || beats[0].vc !== 1'b1) begin
            fails++;
            $display("FAIL mid_after_beat: got data %0h empty %0d sop %0b eop %0b vc %0b expected 5aa 9 1 1 1", beats[0].data, beats[0].empty, beats[0].sop, beats[0].eop, beats[0].vc);
         end
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_sop    = 1'b0;
      bus.in_eop    = 1'b0;
      bus.in_empty  = '0;
      bus.in_data   = '0;
      bus.i_vc_id   = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_interleave();
      test_ctrl();
      test_truncate();
      test_full();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
